usb_ep_ctrl: RTL and testbench
==============================

# usb_ep_ctrl

Endpoint controller that sits between the `usb` protocol engine's transaction interface and the application. It owns per-endpoint state for up to 16 endpoints: data-toggle bits, IN/OUT armed flags, packet lengths and stall policy. It answers the engine's `handshake`, `data_toggle`, `data_in` and `data_in_valid` requests from that state, and moves payload bytes to and from a shared single-port packet buffer RAM.

## Interface
- `N_EP`, default 4: number of endpoints, 1..16. Derived width `EW = max(1, clog2(N_EP))`.
- `clk_48` in 1: the single clock; everything is `posedge`.
- `rst` in 1: asynchronous, active-high reset.
- `usb_rst` in 1: bus reset from the engine, applied synchronously.
- `transaction_active`, `direction_in`, `setup` in 1; `endpoint` in 4: engine transaction context.
- `data_strobe`, `success` in 1; `data_out` in 8: engine byte strobe, completion pulse and received byte.
- `handshake` out 2: encoding ack=00, none=01, nak=10, stall=11. Combinational.
- `data_toggle` out 1: combinational.
- `data_in` out 8; `data_in_valid` out 1: IN payload byte and its valid flag.
- `ep_stall` in N_EP: per-endpoint stall level from the application.
- `in_arm` in 1, `in_arm_ep` in EW, `in_arm_len` in 7: one-cycle request that arms an IN packet.
- `out_arm` in 1, `out_arm_ep` in EW: one-cycle request that arms reception of an OUT packet.
- `in_done` out 1, `out_done` out 1: one-cycle completion pulses.
- `done_ep` out EW, `out_len` out 7, `out_setup` out 1: completion details, valid with the pulse.
- `buf_addr` out EW+7, `buf_we` out 1, `buf_wdata` out 8: packet RAM address, write enable and write data.
- `buf_rdata` in 8: packet RAM read data, one-cycle read latency.

## Operation
- **Buffer map.** `buf_addr = {ep, dir, idx[5:0]}`, with dir 1 = IN and dir 0 = OUT. Each endpoint has a 64-byte slot per direction.
- **Per-endpoint registers.** `in_ready`, `in_len[6:0]`, `out_ready`, `tog_in`, `tog_out`.
- **Arming.** `in_arm` sets `in_ready` and loads `in_len = min(in_arm_len, 64)`. `out_arm` sets `out_ready`. Arming an endpoint that is already armed re-arms it and overwrites `in_len`.
- **Current endpoint.** `cur = endpoint`. If `endpoint >= N_EP`, `handshake` = stall.
- **IN handshake.** stall if `ep_stall[cur]`, else ack if `in_ready`, else nak.
- **OUT handshake.**
  - With `setup` = 1: always ack. A SETUP is never refused.
  - With `setup` = 0: stall if `ep_stall`, else ack if `out_ready`, else nak.
- **Data toggle.** `data_toggle` = `tog_in[cur]` when `direction_in`, else `tog_out[cur]`. While `setup` = 1, `data_toggle` = 0.
- **FSM states.** IDLE, IN, OUT, DONE.
  - IDLE → IN or OUT when `transaction_active` = 1, choosing by `direction_in`. On entry, the context (ep, dir, setup) is latched and `idx` = 0.
  - IN/OUT → DONE when `success` = 1.
  - IN/OUT → IDLE when `transaction_active` falls with no `success`. The transfer is discarded and flags/toggles are unchanged.
  - IN/OUT restarts with `idx` = 0 and the new context latched if `endpoint`, `direction_in` or `setup` changes while `transaction_active` stays high (a new token).
  - DONE → IDLE once `transaction_active` = 0.
- **IN transfer.**
  - `data_in_valid = (state == IN) && idx < in_len[ep]`.
  - `data_in` = `buf_rdata` of `{ep, 1, idx}`.
  - `data_strobe` increments `idx`.
  - On `success`: pulse `in_done`, set `done_ep`, clear `in_ready`, flip `tog_in`.
- **OUT transfer.**
  - `data_strobe` writes `data_out` to `{ep, 0, idx}` (`buf_we` = 1 that cycle), then `idx++`.
  - At `idx` = 64, further bytes are dropped: no write, and `idx` saturates.
  - On `success`: pulse `out_done`, set `out_len = idx`, `out_setup = setup`, `done_ep`; clear `out_ready`; flip `tog_out`.
  - On a SETUP `success`: set `tog_out` = 1 and `tog_in` = 1 instead of flipping.
- **Arm and done collide.** If an arm and a done for the same endpoint/direction occur in the same cycle, the arm wins and the ready flag stays 1.
- **Bus reset.** `usb_rst` clears all ready flags and toggles, moves the FSM to IDLE, and suppresses done pulses.

## Timing
- **Reset values.** All registered outputs and state are 0 and the FSM is in IDLE. `handshake` reset value with the endpoint at 0: nak if `ep_stall[0]` = 0, else stall.
- **Combinational outputs.** `handshake` and `data_toggle` have zero latency from `endpoint`, `direction_in`, `setup` and the flags. The engine latches them in the same cycle as the DATA PID.
- **IN data path.** `data_in` is valid 2 cycles after FSM entry or after `data_strobe`. The engine samples no sooner than 32 cycles later.
- **Done pulses.** `in_done` / `out_done` assert exactly 1 cycle after `success`.
- **Flag updates.** Ready flags and toggles update in that same cycle.
- **OUT writes.** The `buf_we` write occurs in the cycle after `data_strobe`, with address, data and enable registered together.
- **Reset mid-transfer.** Asserting `rst` or `usb_rst` mid-transfer leaves no partial flag or toggle update.

## Test plan
- **IN transfer.** Arm EP1 IN, len 3, RAM holds 0xA1, 0xA2, 0xA3. Run an IN transaction on EP1 → `handshake` = ack, `data_toggle` = 0. Three strobes see 0xA1, 0xA2, 0xA3, then `data_in_valid` = 0. After `success`: `in_done`, `done_ep` = 1, `tog_in[1]` = 1, next IN returns nak.
- **OUT transfer and overflow.** Arm EP2 OUT and deliver 70 bytes 0x00..0x45 → exactly 64 RAM writes, 0x00..0x3F at `{2, 0, 0..63}`. On `success`: `out_len` = 64, `out_done`, `tog_out[2]` = 1.
- **SETUP.** SETUP on EP0 with `out_ready` = 0 and `ep_stall[0]` = 1 → `handshake` = ack, `data_toggle` = 0. On `success`: `out_setup` = 1, `tog_in[0]` = `tog_out[0]` = 1.
- **Abort.** Drop `transaction_active` mid-IN with no `success` → no `in_done`, `in_ready` stays 1, toggle unchanged.
- **Policy and endpoint range.** With N_EP = 4: endpoint 5 → stall; `ep_stall[3]` → stall; unarmed EP3 OUT → nak.
- **Collisions and bus reset.** `in_arm` EP1 in the same cycle as its IN `success` → `in_ready` = 1, `in_len` = new value. `usb_rst` mid-OUT → all flags and toggles are 0, no `out_done`.

Source files
------------

// File: rtl/usb_ep_ctrl.sv
// USB endpoint controller: per-endpoint arm/toggle/stall state, handshake and
// toggle answers for the protocol engine, and payload moves to a packet RAM.
module usb_ep_ctrl #(
    parameter int N_EP = 4,
    localparam int EW = (N_EP > 1) ? $clog2(N_EP) : 1
) (
    input  logic            clk_48,
    input  logic            rst,
    input  logic            usb_rst,
    input  logic            transaction_active,
    input  logic            direction_in,
    input  logic            setup,
    input  logic [3:0]      endpoint,
    input  logic            data_strobe,
    input  logic            success,
    input  logic [7:0]      data_out,
    output logic [1:0]      handshake,
    output logic            data_toggle,
    output logic [7:0]      data_in,
    output logic            data_in_valid,
    input  logic [N_EP-1:0] ep_stall,
    input  logic            in_arm,
    input  logic [EW-1:0]   in_arm_ep,
    input  logic [6:0]      in_arm_len,
    input  logic            out_arm,
    input  logic [EW-1:0]   out_arm_ep,
    output logic            in_done,
    output logic            out_done,
    output logic [EW-1:0]   done_ep,
    output logic [6:0]      out_len,
    output logic            out_setup,
    output logic [EW+6:0]   buf_addr,
    output logic            buf_we,
    output logic [7:0]      buf_wdata,
    input  logic [7:0]      buf_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IN   = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] HS_ACK   = 2'b00;
    localparam logic [1:0] HS_NAK   = 2'b10;
    localparam logic [1:0] HS_STALL = 2'b11;
    localparam logic [4:0] N_EP_W   = 5'(N_EP);
    localparam logic [6:0] MAX_PKT  = 7'd64;

    logic [N_EP-1:0] in_ready_r;
    logic [N_EP-1:0] out_ready_r;
    logic [N_EP-1:0] tog_in_r;
    logic [N_EP-1:0] tog_out_r;
    logic [6:0]      in_len_r [N_EP];

    state_t          state_r;
    state_t          state_s;
    logic [3:0]      tok_ep_r;
    logic [3:0]      tok_ep_s;
    logic            tok_setup_r;
    logic            tok_setup_s;
    logic [6:0]      idx_r;
    logic [6:0]      idx_s;
    logic [EW-1:0]   ep_s;
    logic [EW-1:0]   cur_s;
    logic            cur_valid_s;
    logic            ctx_chg_s;
    logic            in_fin_s;
    logic            out_fin_s;
    logic            wr_s;
    logic [EW+6:0]   buf_addr_s;
    logic [6:0]      arm_len_s;

    assign ep_s        = tok_ep_r[EW-1:0];
    assign cur_s       = endpoint[EW-1:0];
    assign cur_valid_s = ({1'b0, endpoint} < N_EP_W);
    assign arm_len_s   = (in_arm_len > MAX_PKT) ? MAX_PKT : in_arm_len;
    assign ctx_chg_s   = (endpoint != tok_ep_r) || (setup != tok_setup_r) ||
                         (direction_in != (state_r == ST_IN));

    assign data_in_valid = (state_r == ST_IN) && (idx_r < in_len_r[ep_s]);

    // Handshake and toggle answers, zero latency from the token context.
    always_comb begin
        handshake   = HS_NAK;
        data_toggle = 1'b0;
        if (!cur_valid_s) begin
            handshake = HS_STALL;
        end else if (direction_in) begin
            if (ep_stall[cur_s]) begin
                handshake = HS_STALL;
            end else if (in_ready_r[cur_s]) begin
                handshake = HS_ACK;
            end else begin
                handshake = HS_NAK;
            end
            data_toggle = setup ? 1'b0 : tog_in_r[cur_s];
        end else if (setup) begin
            // A SETUP must always be accepted, whatever the stall policy.
            handshake = HS_ACK;
        end else begin
            if (ep_stall[cur_s]) begin
                handshake = HS_STALL;
            end else if (out_ready_r[cur_s]) begin
                handshake = HS_ACK;
            end else begin
                handshake = HS_NAK;
            end
            data_toggle = tog_out_r[cur_s];
        end
    end

    // Transfer FSM next state, context latch and byte index.
    always_comb begin
        state_s     = state_r;
        tok_ep_s    = tok_ep_r;
        tok_setup_s = tok_setup_r;
        idx_s       = idx_r;
        in_fin_s    = 1'b0;
        out_fin_s   = 1'b0;
        wr_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (transaction_active && cur_valid_s) begin
                    state_s     = direction_in ? ST_IN : ST_OUT;
                    tok_ep_s    = endpoint;
                    tok_setup_s = setup;
                    idx_s       = 7'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_IN, ST_OUT: begin
                if (success) begin
                    state_s   = ST_DONE;
                    in_fin_s  = (state_r == ST_IN);
                    out_fin_s = (state_r == ST_OUT);
                end else if (!transaction_active) begin
                    state_s = ST_IDLE;
                end else if (ctx_chg_s) begin
                    // A new token arrived without the bus going idle.
                    if (cur_valid_s) begin
                        state_s     = direction_in ? ST_IN : ST_OUT;
                        tok_ep_s    = endpoint;
                        tok_setup_s = setup;
                        idx_s       = 7'd0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (data_strobe && (idx_r < MAX_PKT)) begin
                    idx_s = idx_r + 7'd1;
                    wr_s  = (state_r == ST_OUT);
                end else begin
                    state_s = state_r;
                end
            end
            ST_DONE: begin
                if (!transaction_active) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Buffer address: OUT writes use the pre-increment index, IN reads prefetch.
    always_comb begin
        buf_addr_s = buf_addr;
        if (wr_s) begin
            buf_addr_s = {ep_s, 1'b0, idx_r[5:0]};
        end else if (state_s == ST_IN) begin
            buf_addr_s = {tok_ep_s[EW-1:0], 1'b1, idx_s[5:0]};
        end else begin
            buf_addr_s = buf_addr;
        end
    end

    // FSM state, buffer port and completion outputs.
    always_ff @(posedge clk_48 or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            tok_ep_r    <= 4'd0;
            tok_setup_r <= 1'b0;
            idx_r       <= 7'd0;
            buf_addr    <= '0;
            buf_we      <= 1'b0;
            buf_wdata   <= 8'd0;
            data_in     <= 8'd0;
            in_done     <= 1'b0;
            out_done    <= 1'b0;
            done_ep     <= '0;
            out_len     <= 7'd0;
            out_setup   <= 1'b0;
        end else if (usb_rst) begin
            state_r     <= ST_IDLE;
            tok_ep_r    <= 4'd0;
            tok_setup_r <= 1'b0;
            idx_r       <= 7'd0;
            buf_we      <= 1'b0;
            data_in     <= buf_rdata;
            in_done     <= 1'b0;
            out_done    <= 1'b0;
        end else begin
            state_r     <= state_s;
            tok_ep_r    <= tok_ep_s;
            tok_setup_r <= tok_setup_s;
            idx_r       <= idx_s;
            buf_addr    <= buf_addr_s;
            buf_we      <= wr_s;
            data_in     <= buf_rdata;
            in_done     <= in_fin_s;
            out_done    <= out_fin_s;
            if (wr_s) begin
                buf_wdata <= data_out;
            end
            if (in_fin_s || out_fin_s) begin
                done_ep <= ep_s;
            end
            if (out_fin_s) begin
                out_len   <= idx_r;
                out_setup <= tok_setup_r;
            end
        end
    end

    // Per-endpoint ready flags, IN lengths and data toggles; arming beats completion.
    always_ff @(posedge clk_48 or posedge rst) begin
        if (rst) begin
            in_ready_r  <= '0;
            out_ready_r <= '0;
            tog_in_r    <= '0;
            tog_out_r   <= '0;
            for (int e = 0; e < N_EP; e++) begin
                in_len_r[e] <= 7'd0;
            end
        end else if (usb_rst) begin
            in_ready_r  <= '0;
            out_ready_r <= '0;
            tog_in_r    <= '0;
            tog_out_r   <= '0;
        end else begin
            for (int e = 0; e < N_EP; e++) begin
                if (in_arm && (in_arm_ep == EW'(e))) begin
                    in_ready_r[e] <= 1'b1;
                    in_len_r[e]   <= arm_len_s;
                end else if (in_fin_s && (ep_s == EW'(e))) begin
                    in_ready_r[e] <= 1'b0;
                end
                if (out_arm && (out_arm_ep == EW'(e))) begin
                    out_ready_r[e] <= 1'b1;
                end else if (out_fin_s && (ep_s == EW'(e))) begin
                    out_ready_r[e] <= 1'b0;
                end
                if (in_fin_s && (ep_s == EW'(e))) begin
                    tog_in_r[e] <= ~tog_in_r[e];
                end else if (out_fin_s && tok_setup_r && (ep_s == EW'(e))) begin
                    tog_in_r[e] <= 1'b1;
                end
                if (out_fin_s && (ep_s == EW'(e))) begin
                    tog_out_r[e] <= tok_setup_r ? 1'b1 : ~tog_out_r[e];
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_ep_ctrl.sv
// Directed bench for usb_ep_ctrl with a behavioural packet RAM (1-cycle read).
module tb_usb_ep_ctrl;

    localparam int N_EP = 4;
    localparam int EW   = 2;

    logic            clk_48 = 1'b0;
    logic            rst;
    logic            usb_rst;
    logic            transaction_active;
    logic            direction_in;
    logic            setup;
    logic [3:0]      endpoint;
    logic            data_strobe;
    logic            success;
    logic [7:0]      data_out;
    logic [1:0]      handshake;
    logic            data_toggle;
    logic [7:0]      data_in;
    logic            data_in_valid;
    logic [N_EP-1:0] ep_stall;
    logic            in_arm;
    logic [EW-1:0]   in_arm_ep;
    logic [6:0]      in_arm_len;
    logic            out_arm;
    logic [EW-1:0]   out_arm_ep;
    logic            in_done;
    logic            out_done;
    logic [EW-1:0]   done_ep;
    logic [6:0]      out_len;
    logic            out_setup;
    logic [EW+6:0]   buf_addr;
    logic            buf_we;
    logic [7:0]      buf_wdata;
    logic [7:0]      buf_rdata;

    logic [7:0]      ram [0:511];
    logic            pre_we;
    logic [8:0]      pre_addr;
    logic [7:0]      pre_data;
    int              wr_cnt = 0;
    int              wr_base;
    logic [8:0]      ad;
    int              n_tests = 0;
    int              n_fail = 0;

    always #5 clk_48 = ~clk_48;

    usb_ep_ctrl #(.N_EP(N_EP)) dut (
        .clk_48(clk_48), .rst(rst), .usb_rst(usb_rst),
        .transaction_active(transaction_active), .direction_in(direction_in),
        .setup(setup), .endpoint(endpoint), .data_strobe(data_strobe),
        .success(success), .data_out(data_out), .handshake(handshake),
        .data_toggle(data_toggle), .data_in(data_in), .data_in_valid(data_in_valid),
        .ep_stall(ep_stall), .in_arm(in_arm), .in_arm_ep(in_arm_ep),
        .in_arm_len(in_arm_len), .out_arm(out_arm), .out_arm_ep(out_arm_ep),
        .in_done(in_done), .out_done(out_done), .done_ep(done_ep),
        .out_len(out_len), .out_setup(out_setup), .buf_addr(buf_addr),
        .buf_we(buf_we), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata)
    );

    // Packet RAM model with a bench-side preload port.
    always @(posedge clk_48) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (buf_we) begin
            ram[buf_addr] <= buf_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        buf_rdata <= ram[buf_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_48);
            #1;
        end
    endtask

    task automatic strobe_byte(input logic [7:0] b);
        data_out    = b;
        data_strobe = 1'b1;
        cyc(1);
        data_strobe = 1'b0;
        cyc(1);
    endtask

    initial begin
        rst = 1'b1; usb_rst = 1'b0; transaction_active = 1'b0; direction_in = 1'b0;
        setup = 1'b0; endpoint = 4'd0; data_strobe = 1'b0; success = 1'b0;
        data_out = 8'd0; ep_stall = 4'b0000; in_arm = 1'b0; in_arm_ep = 2'd0;
        in_arm_len = 7'd0; out_arm = 1'b0; out_arm_ep = 2'd0;
        pre_we = 1'b0; pre_addr = 9'd0; pre_data = 8'd0;
        cyc(2);
        rst = 1'b0;
        cyc(1);

        // Reset state
        chk("rst_hs_nak", 32'(handshake), 32'd2);
        chk("rst_tog", 32'(data_toggle), 32'd0);
        chk("rst_in_done", 32'(in_done), 32'd0);
        chk("rst_out_done", 32'(out_done), 32'd0);
        chk("rst_buf_we", 32'(buf_we), 32'd0);
        chk("rst_valid", 32'(data_in_valid), 32'd0);
        chk("rst_out_len", 32'(out_len), 32'd0);
        ep_stall = 4'b0001; #1;
        chk("rst_hs_stall", 32'(handshake), 32'd3);
        ep_stall = 4'b0000;

        for (int k = 0; k < 3; k++) begin
            pre_we = 1'b1; pre_addr = {2'd1, 1'b1, 6'(k)}; pre_data = 8'(8'hA1 + k);
            cyc(1);
        end
        pre_we = 1'b0;

        // IN transfer on EP1, three bytes
        in_arm = 1'b1; in_arm_ep = 2'd1; in_arm_len = 7'd3;
        cyc(1);
        in_arm = 1'b0;
        endpoint = 4'd1; direction_in = 1'b1; setup = 1'b0; #1;
        chk("in_hs_ack", 32'(handshake), 32'd0);
        chk("in_tog0", 32'(data_toggle), 32'd0);
        transaction_active = 1'b1;
        cyc(3);
        for (int k = 0; k < 3; k++) begin
            chk("in_valid", 32'(data_in_valid), 32'd1);
            chk("in_byte", 32'(data_in), 32'(8'hA1 + k));
            data_strobe = 1'b1; cyc(1); data_strobe = 1'b0; cyc(2);
        end
        chk("in_valid_end", 32'(data_in_valid), 32'd0);
        success = 1'b1; cyc(1); success = 1'b0;
        chk("in_done", 32'(in_done), 32'd1);
        chk("in_done_ep", 32'(done_ep), 32'd1);
        chk("in_hs_nak_after", 32'(handshake), 32'd2);
        chk("in_tog1", 32'(data_toggle), 32'd1);
        cyc(1);
        chk("in_done_pulse", 32'(in_done), 32'd0);
        transaction_active = 1'b0;
        cyc(1);

        // OUT transfer on EP2 with 70 bytes, 64 kept
        out_arm = 1'b1; out_arm_ep = 2'd2;
        cyc(1);
        out_arm = 1'b0;
        endpoint = 4'd2; direction_in = 1'b0; #1;
        chk("out_hs_ack", 32'(handshake), 32'd0);
        chk("out_tog0", 32'(data_toggle), 32'd0);
        wr_base = wr_cnt;
        transaction_active = 1'b1;
        cyc(1);
        for (int b = 0; b < 70; b++) strobe_byte(8'(b));
        success = 1'b1; cyc(1); success = 1'b0;
        chk("out_done", 32'(out_done), 32'd1);
        chk("out_len64", 32'(out_len), 32'd64);
        chk("out_done_ep", 32'(done_ep), 32'd2);
        chk("out_setup0", 32'(out_setup), 32'd0);
        chk("out_tog1", 32'(data_toggle), 32'd1);
        chk("out_hs_nak_after", 32'(handshake), 32'd2);
        cyc(1);
        chk("out_done_pulse", 32'(out_done), 32'd0);
        chk("out_wr_count", 32'(wr_cnt - wr_base), 32'd64);
        transaction_active = 1'b0;
        cyc(1);
        for (int k = 0; k < 64; k++) begin
            ad = {2'd2, 1'b0, 6'(k)};
            chk("out_ram", 32'(ram[ad]), 32'(k));
        end

        // SETUP on stalled, unarmed EP0
        ep_stall = 4'b0001; endpoint = 4'd0; direction_in = 1'b0; setup = 1'b0; #1;
        chk("ep0_hs_stall", 32'(handshake), 32'd3);
        setup = 1'b1; #1;
        chk("setup_hs_ack", 32'(handshake), 32'd0);
        chk("setup_tog0", 32'(data_toggle), 32'd0);
        transaction_active = 1'b1;
        cyc(1);
        strobe_byte(8'h80);
        strobe_byte(8'h06);
        success = 1'b1; cyc(1); success = 1'b0;
        chk("setup_done", 32'(out_done), 32'd1);
        chk("setup_flag", 32'(out_setup), 32'd1);
        chk("setup_len", 32'(out_len), 32'd2);
        chk("setup_ep", 32'(done_ep), 32'd0);
        setup = 1'b0; direction_in = 1'b1; #1;
        chk("setup_tog_in", 32'(data_toggle), 32'd1);
        direction_in = 1'b0; #1;
        chk("setup_tog_out", 32'(data_toggle), 32'd1);
        transaction_active = 1'b0; ep_stall = 4'b0000;
        cyc(1);

        // Abort mid-IN on EP3
        in_arm = 1'b1; in_arm_ep = 2'd3; in_arm_len = 7'd5;
        cyc(1);
        in_arm = 1'b0;
        endpoint = 4'd3; direction_in = 1'b1; transaction_active = 1'b1;
        cyc(1);
        strobe_byte(8'h00);
        transaction_active = 1'b0;
        cyc(1);
        chk("abort_no_done", 32'(in_done), 32'd0);
        cyc(1);
        chk("abort_no_done2", 32'(in_done), 32'd0);
        chk("abort_ready", 32'(handshake), 32'd0);
        chk("abort_tog", 32'(data_toggle), 32'd0);

        // Policy and endpoint range
        endpoint = 4'd5; #1;
        chk("ep_range_stall", 32'(handshake), 32'd3);
        ep_stall = 4'b1000; endpoint = 4'd3; direction_in = 1'b1; #1;
        chk("ep3_stall", 32'(handshake), 32'd3);
        ep_stall = 4'b0000; direction_in = 1'b0; #1;
        chk("ep3_out_nak", 32'(handshake), 32'd2);

        // Arm colliding with IN completion on EP1
        in_arm = 1'b1; in_arm_ep = 2'd1; in_arm_len = 7'd2;
        cyc(1);
        in_arm = 1'b0;
        endpoint = 4'd1; direction_in = 1'b1; transaction_active = 1'b1;
        cyc(1);
        in_arm = 1'b1; in_arm_len = 7'd100; success = 1'b1;
        cyc(1);
        in_arm = 1'b0; success = 1'b0;
        chk("coll_done", 32'(in_done), 32'd1);
        chk("coll_ready", 32'(handshake), 32'd0);
        chk("coll_tog", 32'(data_toggle), 32'd0);
        transaction_active = 1'b0;
        cyc(1);
        transaction_active = 1'b1;
        cyc(1);
        for (int k = 0; k < 64; k++) begin
            if (k == 2 || k == 63) chk("coll_len_valid", 32'(data_in_valid), 32'd1);
            data_strobe = 1'b1; cyc(1); data_strobe = 1'b0; cyc(1);
        end
        chk("coll_len_clamp", 32'(data_in_valid), 32'd0);
        transaction_active = 1'b0;
        cyc(1);

        // Bus reset mid-OUT on EP2
        out_arm = 1'b1; out_arm_ep = 2'd2;
        cyc(1);
        out_arm = 1'b0;
        endpoint = 4'd2; direction_in = 1'b0; transaction_active = 1'b1;
        cyc(1);
        strobe_byte(8'h11);
        strobe_byte(8'h22);
        usb_rst = 1'b1; success = 1'b1;
        cyc(1);
        usb_rst = 1'b0; success = 1'b0;
        chk("usbrst_no_done", 32'(out_done), 32'd0);
        chk("usbrst_out_nak", 32'(handshake), 32'd2);
        chk("usbrst_tog_out2", 32'(data_toggle), 32'd0);
        endpoint = 4'd0; direction_in = 1'b1; #1;
        chk("usbrst_tog_in0", 32'(data_toggle), 32'd0);
        direction_in = 1'b0; #1;
        chk("usbrst_tog_out0", 32'(data_toggle), 32'd0);
        endpoint = 4'd3; direction_in = 1'b1; #1;
        chk("usbrst_in3_nak", 32'(handshake), 32'd2);
        cyc(1);
        chk("usbrst_no_done2", 32'(out_done), 32'd0);
        transaction_active = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
